ram_stream_reader: RTL and testbench
====================================

// Module: ram_stream_reader
// PURPOSE
//  Sequential read-out engine sitting directly downstream of the dual-port ram: drives one ram
//  port's read enable/address over an address range and forwards each word on a valid/ready
//  stream (e.g. to a UART tx or display driver). Absorbs the ram's 1-cycle registered read
//  latency; holds each word stable until the consumer accepts it.
// PARAMETERS
//  ADDR_BITS  3               ram address width
//  WORD_BITS  8               ram/stream word width
//  NUM_WORDS  2**ADDR_BITS    ram depth; address wraps modulo NUM_WORDS
// PORTS
//  in_clk            in   1          system clock, rising edge
//  in_rst            in   1          reset, asynchronous, active-low
//  in_start          in   1          start a transfer (sampled in IDLE only)
//  in_first_addr     in   ADDR_BITS  first address of range (sampled with in_start)
//  in_last_addr      in   ADDR_BITS  last address of range, inclusive (sampled with in_start)
//  out_ram_read_ena  out  1          to ram in_read_ena[port]
//  out_ram_addr      out  ADDR_BITS  to ram in_addr[port]
//  in_ram_data       in   WORD_BITS  from ram out_data[port]
//  out_data          out  WORD_BITS  stream word
//  out_valid         out  1          stream word valid
//  in_ready          in   1          consumer ready; transfer when out_valid & in_ready at edge
//  out_busy          out  1          high in any state except IDLE
//  out_done          out  1          one-cycle pulse after final word accepted
// BEHAVIOUR
//  - Reset (in_rst=0, any time, incl. mid-transfer): state IDLE; all outputs 0; counters/
//    checksum cleared; an in-flight word is discarded. Must not depend on in_clk.
//  - States: IDLE, READ, LATCH, OUT, [CSUM], DONE.
//  - IDLE: in_start=1 -> latch cur_addr=in_first_addr, remaining=(last-first) mod NUM_WORDS;
//    go READ. in_start in any other state is ignored.
//  - READ: out_ram_read_ena=1, out_ram_addr=cur_addr (1 cycle) -> LATCH.
//  - LATCH: out_ram_read_ena=0 (ram data register valid this cycle); out_data<=in_ram_data -> OUT.
//  - OUT: out_valid=1, out_data held stable while in_ready=0. On handshake: if remaining==0
//    -> DONE (or CSUM if enabled); else cur_addr<=cur_addr+1 (wraps NUM_WORDS-1 -> 0),
//    remaining<=remaining-1 -> READ.
//  - DONE: out_done=1 for exactly one cycle -> IDLE.
//  - Latency: in_start edge -> out_valid high 3 cycles later; min 3 cycles/word with in_ready=1.
//  - Word count = ((in_last_addr-in_first_addr) mod NUM_WORDS)+1; first==last -> 1 word;
//    last<first -> wrap-around range; full ram = last==first-1 mod NUM_WORDS.
//  - out_ram_addr is 0 whenever out_ram_read_ena=0; out_data 0 in IDLE.
//  - Counters are ADDR_BITS wide; all address arithmetic modulo 2**ADDR_BITS.
// CONFIGURATION
//  RAM_STREAM_CHECKSUM_EN defined: after final data handshake enter CSUM: out_valid=1,
//    out_data = XOR of all words sent in this transfer; handshake -> DONE. Stream length +1.
//  Not defined: no CSUM state, no accumulator; OUT -> DONE directly.
// STRUCTURE
//  Package ram_stream_pkg: typedef enum logic [2:0] t_state {IDLE,READ,LATCH,OUT,CSUM,DONE}
//  (CSUM encoding reserved even when disabled), READ_LATENCY=1 constant.
//  No sub-module: single FSM with address/remaining counters and optional XOR accumulator.
// TESTING (bench instantiates ram + ram_stream_reader, ram preloaded 8'h31..8'h38 at addr 0..7)
//  1. start first=2,last=4, in_ready=1 -> stream 33,34,35; out_valid 3 cycles after start; done pulse.
//  2. first=6,last=1 -> wrap: 37,38,31,32 then out_done; out_busy high throughout.
//  3. first=last=5, in_ready low 10 cycles -> out_data=36 stable, out_valid held; accept once.
//  4. in_rst=0 mid-transfer (after 2nd word) -> all outputs 0 immediately; new start works.
//  5. in_start pulsed while busy -> ignored; range unchanged.
//  6. RAM_STREAM_CHECKSUM_EN, first=0,last=1 -> 31,32, then checksum 8'h03, then out_done.

Source files
------------

// File: rtl/ram_stream_reader_pkg.sv
// ram_stream_pkg: shared types and constants for ram_stream_reader.
//   t_state      FSM state encoding. CSUM keeps its code even when the checksum
//                feature (RAM_STREAM_CHECKSUM_EN) is compiled out.
//   READ_LATENCY registered read latency of the upstream ram, in cycles.
package ram_stream_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    LATCH = 3'd2,
    OUT   = 3'd3,
    CSUM  = 3'd4,
    DONE  = 3'd5
  } t_state;

  localparam int unsigned READ_LATENCY = 1;

endpackage

// File: rtl/ram_stream_reader.sv
// ram_stream_reader: walks an inclusive, wrapping address range of a ram port
// (registered read, 1-cycle latency) and forwards each word on a valid/ready
// stream, holding the word stable until it is accepted.
//
// Optional feature macro: RAM_STREAM_CHECKSUM_EN -- when defined, an extra
// stream word carrying the XOR of all words of the transfer follows the data.
//
// Ports
//   in_clk            system clock, rising edge
//   in_rst            asynchronous active-low reset
//   in_start          start a transfer (sampled in IDLE only)
//   in_first_addr     first address of the range (sampled with in_start)
//   in_last_addr      last address of the range, inclusive
//   out_ram_read_ena  ram read enable
//   out_ram_addr      ram address (0 whenever read enable is low)
//   in_ram_data       ram read data
//   out_data          stream word (0 in IDLE)
//   out_valid         stream word valid
//   in_ready          consumer ready
//   out_busy          high in every state except IDLE
//   out_done          one-cycle pulse after the final word is accepted
module ram_stream_reader
  import ram_stream_pkg::*;
#(
  parameter int unsigned ADDR_BITS = 3,
  parameter int unsigned WORD_BITS = 8,
  parameter int unsigned NUM_WORDS = 2**ADDR_BITS
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic                 in_start,
  input  logic [ADDR_BITS-1:0] in_first_addr,
  input  logic [ADDR_BITS-1:0] in_last_addr,
  output logic                 out_ram_read_ena,
  output logic [ADDR_BITS-1:0] out_ram_addr,
  input  logic [WORD_BITS-1:0] in_ram_data,
  output logic [WORD_BITS-1:0] out_data,
  output logic                 out_valid,
  input  logic                 in_ready,
  output logic                 out_busy,
  output logic                 out_done
);

  t_state               state;
  t_state               state_next;
  logic [ADDR_BITS-1:0] cur_addr;
  logic [ADDR_BITS-1:0] remaining;
  logic [ADDR_BITS-1:0] next_addr;
  logic [WORD_BITS-1:0] data_q;
  logic                 last_word;

`ifdef RAM_STREAM_CHECKSUM_EN
  logic [WORD_BITS-1:0] csum_q;
`endif

  assign last_word = (remaining == '0);
  assign next_addr = (cur_addr == ADDR_BITS'(NUM_WORDS - 1)) ? '0
                                                            : cur_addr + ADDR_BITS'(1);

  // State register
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:  if (in_start) state_next = READ;
      READ:  state_next = LATCH;
      LATCH: state_next = OUT;
      OUT: begin
        if (in_ready) begin
          if (last_word) begin
`ifdef RAM_STREAM_CHECKSUM_EN
            state_next = CSUM;
`else
            state_next = DONE;
`endif
          end else begin
            state_next = READ;
          end
        end
      end
`ifdef RAM_STREAM_CHECKSUM_EN
      CSUM:  if (in_ready) state_next = DONE;
`else
      CSUM:  state_next = IDLE;
`endif
      DONE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    out_ram_read_ena = (state == READ);
    out_ram_addr     = (state == READ) ? cur_addr : '0;
`ifdef RAM_STREAM_CHECKSUM_EN
    out_valid        = (state == OUT) || (state == CSUM);
`else
    out_valid        = (state == OUT);
`endif
    out_busy         = (state != IDLE);
    out_done         = (state == DONE);
    out_data         = (state == IDLE) ? '0 : data_q;
  end

  // Address / remaining counters and the output word register
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      cur_addr  <= '0;
      remaining <= '0;
      data_q    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_start) begin
            cur_addr  <= in_first_addr;
            // modulo-2**ADDR_BITS difference: last<first yields the wrapped length
            remaining <= in_last_addr - in_first_addr;
            data_q    <= '0;
          end
        end
        // ram output register holds the word addressed in READ during this cycle
        LATCH: data_q <= in_ram_data;
        OUT: begin
          if (in_ready) begin
            if (last_word) begin
`ifdef RAM_STREAM_CHECKSUM_EN
              data_q <= csum_q;
`endif
            end else begin
              cur_addr  <= next_addr;
              remaining <= remaining - ADDR_BITS'(1);
            end
          end
        end
        default: ;
      endcase
    end
  end

`ifdef RAM_STREAM_CHECKSUM_EN
  // Accumulated as each word is latched, so it is complete by the final handshake
  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      csum_q <= '0;
    end else if (state == IDLE && in_start) begin
      csum_q <= '0;
    end else if (state == LATCH) begin
      csum_q <= csum_q ^ in_ram_data;
    end
  end
`endif

endmodule

// File: tb/tb_ram_stream_reader.sv
// tb_ram_stream_reader: directed bench for ram_stream_reader with a behavioural
// registered-read ram preloaded with 8'h31..8'h38 at addresses 0..7.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_ram_stream_reader;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] first_addr;
  logic [2:0] last_addr;
  logic       ram_read_ena;
  logic [2:0] ram_addr;
  logic [7:0] ram_data;
  logic [7:0] data;
  logic       valid;
  logic       ready;
  logic       busy;
  logic       done;

  logic [7:0] mem [8];

  int unsigned checks = 0;
  int unsigned errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_read_ena) ram_data <= mem[ram_addr];
  end

  ram_stream_reader #(
    .ADDR_BITS(3),
    .WORD_BITS(8),
    .NUM_WORDS(8)
  ) dut (
    .in_clk          (clk),
    .in_rst          (rst_n),
    .in_start        (start),
    .in_first_addr   (first_addr),
    .in_last_addr    (last_addr),
    .out_ram_read_ena(ram_read_ena),
    .out_ram_addr    (ram_addr),
    .in_ram_data     (ram_data),
    .out_data        (data),
    .out_valid       (valid),
    .in_ready        (ready),
    .out_busy        (busy),
    .out_done        (done)
  );

  // Called on a falling edge; returns on the falling edge after the sampling rising edge.
  task automatic do_start(input logic [2:0] f, input logic [2:0] l);
    first_addr = f;
    last_addr  = l;
    start      = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Polls falling edges until valid is seen, bounded.
  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 12; i++) begin
      if (valid === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; ready = 1'b0; first_addr = '0; last_addr = '0;
    #3;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", valid); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
    checks++; if (ram_read_ena !== 1'b0) begin errors++; $display("FAIL reset_rd: got %b expected 0", ram_read_ena); end
    checks++; if (ram_addr !== 3'd0) begin errors++; $display("FAIL reset_addr: got %h expected 0", ram_addr); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL reset_data: got %h expected 00", data); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_basic;
    bit ok;
    logic [7:0] exp [3];
    exp[0] = 8'h33; exp[1] = 8'h34; exp[2] = 8'h35;
    ready = 1'b1;
    do_start(3'd2, 3'd4);
    checks++; if (ram_read_ena !== 1'b1) begin errors++; $display("FAIL t1_read_ena: got %b expected 1", ram_read_ena); end
    checks++; if (ram_addr !== 3'd2) begin errors++; $display("FAIL t1_read_addr: got %h expected 2", ram_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL t1_valid_c1: got %b expected 0", valid); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (ram_read_ena !== 1'b0) begin errors++; $display("FAIL t1_latch_rd: got %b expected 0", ram_read_ena); end
    checks++; if (ram_addr !== 3'd0) begin errors++; $display("FAIL t1_latch_addr: got %h expected 0", ram_addr); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL t1_valid_c2: got %b expected 0", valid); end
    @(negedge clk);
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL t1_valid_c3: got %b expected 1", valid); end
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL t1_timeout word %0d: got no valid expected valid", k); end
      checks++; if (data !== exp[k]) begin errors++; $display("FAIL t1_data word %0d: got %h expected %h", k, data, exp[k]); end
      @(negedge clk);
    end
`ifdef RAM_STREAM_CHECKSUM_EN
    checks++; if (valid !== 1'b1 || data !== 8'h32) begin errors++; $display("FAIL t1_csum: got %b/%h expected 1/32", valid, data); end
    @(negedge clk);
`endif
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t1_done: got %b expected 1", done); end
    @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL t1_done_pulse: got %b expected 0", done); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t1_idle_busy: got %b expected 0", busy); end
    checks++; if (data !== 8'h00) begin errors++; $display("FAIL t1_idle_data: got %h expected 00", data); end
  endtask

  task automatic test_wrap;
    bit ok;
    logic [7:0] exp [4];
    exp[0] = 8'h37; exp[1] = 8'h38; exp[2] = 8'h31; exp[3] = 8'h32;
    ready = 1'b1;
    do_start(3'd6, 3'd1);
    for (int k = 0; k < 4; k++) begin
      wait_valid(ok);
      checks++; if (!ok) begin errors++; $display("FAIL t2_timeout word %0d: got no valid expected valid", k); end
      checks++; if (data !== exp[k]) begin errors++; $display("FAIL t2_data word %0d: got %h expected %h", k, data, exp[k]); end
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t2_busy word %0d: got %b expected 1", k, busy); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL t2_early_done word %0d: got %b expected 0", k, done); end
      @(negedge clk);
    end
`ifdef RAM_STREAM_CHECKSUM_EN
    checks++; if (valid !== 1'b1 || data !== 8'h0C) begin errors++; $display("FAIL t2_csum: got %b/%h expected 1/0c", valid, data); end
    @(negedge clk);
`endif
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t2_done: got %b expected 1", done); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL t2_done_busy: got %b expected 1", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t2_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_hold;
    ready = 1'b0;
    do_start(3'd5, 3'd5);
    @(negedge clk);
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      checks++; if (valid !== 1'b1 || data !== 8'h36) begin errors++; $display("FAIL t3_hold cycle %0d: got %b/%h expected 1/36", i, valid, data); end
      @(negedge clk);
    end
    ready = 1'b1;
    checks++; if (valid !== 1'b1 || data !== 8'h36) begin errors++; $display("FAIL t3_accept: got %b/%h expected 1/36", valid, data); end
    @(negedge clk);
`ifdef RAM_STREAM_CHECKSUM_EN
    checks++; if (valid !== 1'b1 || data !== 8'h36) begin errors++; $display("FAIL t3_csum: got %b/%h expected 1/36", valid, data); end
    @(negedge clk);
`endif
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t3_done: got %b expected 1", done); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL t3_valid_after: got %b expected 0", valid); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t3_idle_busy: got %b expected 0", busy); end
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [7:0] exp [2];
    exp[0] = 8'h31; exp[1] = 8'h32;
    ready = 1'b1;
    do_start(3'd0, 3'd7);
    for (int k = 0; k < 2; k++) begin
      wait_valid(ok);
      checks++; if (!ok || data !== exp[k]) begin errors++; $display("FAIL t4_data word %0d: got %b/%h expected 1/%h", k, ok, data, exp[k]); end
      @(negedge clk);
    end
    // now in READ of the third word; reset well away from a rising edge
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t4_rst_busy: got %b expected 0", busy); end
    checks++; if (ram_read_ena !== 1'b0) begin errors++; $display("FAIL t4_rst_rd: got %b expected 0", ram_read_ena); end
    checks++; if (ram_addr !== 3'd0) begin errors++; $display("FAIL t4_rst_addr: got %h expected 0", ram_addr); end
    checks++; if (valid !== 1'b0 || data !== 8'h00 || done !== 1'b0) begin errors++; $display("FAIL t4_rst_stream: got %b/%h/%b expected 0/00/0", valid, data, done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL t4_post_rst: got %b/%b expected 0/0", busy, valid); end
    do_start(3'd3, 3'd3);
    @(negedge clk);
    @(negedge clk);
    checks++; if (valid !== 1'b1 || data !== 8'h34) begin errors++; $display("FAIL t4_restart: got %b/%h expected 1/34", valid, data); end
    @(negedge clk);
`ifdef RAM_STREAM_CHECKSUM_EN
    checks++; if (valid !== 1'b1 || data !== 8'h34) begin errors++; $display("FAIL t4_csum: got %b/%h expected 1/34", valid, data); end
    @(negedge clk);
`endif
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t4_done: got %b expected 1", done); end
    @(negedge clk);
  endtask

  task automatic test_ignore_start;
    bit ok;
    ready = 1'b1;
    do_start(3'd1, 3'd2);
    first_addr = 3'd6;
    last_addr  = 3'd6;
    start      = 1'b1;
    @(negedge clk);
    @(negedge clk);
    start = 1'b0;
    checks++; if (valid !== 1'b1 || data !== 8'h32) begin errors++; $display("FAIL t5_word0: got %b/%h expected 1/32", valid, data); end
    @(negedge clk);
    start = 1'b1;
    checks++; if (ram_read_ena !== 1'b1 || ram_addr !== 3'd2) begin errors++; $display("FAIL t5_addr: got %b/%h expected 1/2", ram_read_ena, ram_addr); end
    @(negedge clk);
    start = 1'b0;
    wait_valid(ok);
    checks++; if (!ok || data !== 8'h33) begin errors++; $display("FAIL t5_word1: got %b/%h expected 1/33", ok, data); end
    @(negedge clk);
`ifdef RAM_STREAM_CHECKSUM_EN
    checks++; if (valid !== 1'b1 || data !== 8'h01) begin errors++; $display("FAIL t5_csum: got %b/%h expected 1/01", valid, data); end
    @(negedge clk);
`endif
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t5_done: got %b expected 1", done); end
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL t5_idle1: got %b expected 0", busy); end
    @(negedge clk);
    checks++; if (busy !== 1'b0 || valid !== 1'b0) begin errors++; $display("FAIL t5_idle2: got %b/%b expected 0/0", busy, valid); end
  endtask

`ifdef RAM_STREAM_CHECKSUM_EN
  task automatic test_checksum;
    bit ok;
    logic [7:0] exp [3];
    exp[0] = 8'h31; exp[1] = 8'h32; exp[2] = 8'h03;
    ready = 1'b1;
    do_start(3'd0, 3'd1);
    for (int k = 0; k < 3; k++) begin
      wait_valid(ok);
      checks++; if (!ok || data !== exp[k]) begin errors++; $display("FAIL t6_word %0d: got %b/%h expected 1/%h", k, ok, data, exp[k]); end
      checks++; if (done !== 1'b0) begin errors++; $display("FAIL t6_early_done %0d: got %b expected 0", k, done); end
      @(negedge clk);
    end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL t6_done: got %b expected 1", done); end
    @(negedge clk);
  endtask
`endif

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h31 + 8'(i);
    test_reset;
    test_basic;
    test_wrap;
    test_hold;
    test_reset_mid;
    test_ignore_start;
`ifdef RAM_STREAM_CHECKSUM_EN
    test_checksum;
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no completion expected completion by 100000");
    $fatal(1, "watchdog");
  end

endmodule
